mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8:1 multiplexer between eight requesters. It registers a one-hot grant and drives the mux select `sel[2:0]` (bit 0 = s0, bit 1 = s1, bit 2 = s2) so the granted requester's input reaches `y`. A grant is held while its owner keeps requesting. An optional burst limit forces rotation when other requesters are waiting.

---
 rtl/mux_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux; grants are held while requested.
// Optional burst limit (forced rotation after MAX_BURST cycles) enabled by ARB_BURST_LIMIT_EN.
module mux_rr_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy
);

   localparam int unsigned NumReq = 8;
   localparam int unsigned IdxW   = 3;
   localparam int unsigned CntW   = 8;
   localparam logic [CntW-1:0] CntSat = CntW'(255);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t            state, state_nxt;
   logic [IdxW-1:0]   last, last_nxt;
   logic [CntW-1:0]   cnt, cnt_nxt;
   logic [NumReq-1:0] gnt_nxt;
   logic [IdxW-1:0]   sel_nxt;
   logic              busy_nxt;

   logic              win_found_c;
   logic [IdxW-1:0]   win_idx_c;
   logic              owner_req_c;
   logic              others_c;
   logic              force_rot_c;

   // Rotating search from last+1; while granting, the owner (== last) is skipped.
   always_comb begin
      logic [IdxW-1:0] idx;
      win_found_c = 1'b0;
      win_idx_c   = last;
      for (int k = 1; k <= int'(NumReq); k++) begin
         idx = last + IdxW'(k);
         if (!win_found_c && req[idx] && !((state == GRANT) && (idx == last))) begin
            win_found_c = 1'b1;
            win_idx_c   = idx;
         end
      end
   end

   assign owner_req_c = req[last];
   assign others_c    = |(req & ~(NumReq'(1) << last));

`ifdef ARB_BURST_LIMIT_EN
   assign force_rot_c = (cnt == CntW'(MAX_BURST)) && others_c;
`else
   assign force_rot_c = 1'b0;
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      case (state)
         IDLE: begin
            if (win_found_c) begin
               state_nxt = GRANT;
               gnt_nxt   = NumReq'(1) << win_idx_c;
               sel_nxt   = win_idx_c;
               last_nxt  = win_idx_c;
               cnt_nxt   = CntW'(1);
            end
         end
         GRANT: begin
            if (owner_req_c && !force_rot_c) begin
               if (cnt != CntSat) begin
                  cnt_nxt = cnt + CntW'(1);
               end
            end else if (win_found_c) begin
               gnt_nxt  = NumReq'(1) << win_idx_c;
               sel_nxt  = win_idx_c;
               last_nxt = win_idx_c;
               cnt_nxt  = CntW'(1);
            end else begin
               // sel and last keep the old owner so the mux output stays stable.
               state_nxt = IDLE;
               gnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
      busy_nxt = |gnt_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= IdxW'(NumReq - 1);
         cnt   <= '0;
         gnt   <= '0;
         sel   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         busy  <= busy_nxt;
      end
   end

   max_burst_range: assert property (@(posedge clk) disable iff (!rst_n)
      (MAX_BURST >= 1) && (MAX_BURST <= 255));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios with literal expectations plus
// randomized requests checked every cycle against an integer-level round-robin model.
module tb_mux_rr_arbiter;

   localparam int unsigned MaxBurst = 4;
`ifdef ARB_BURST_LIMIT_EN
   localparam bit LimitEn = 1'b1;
`else
   localparam bit LimitEn = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Model state: owner index (-1 = idle), priority pointer, run length, mux select.
   int m_owner;
   int m_last;
   int m_run;
   int m_sel;

   mux_rr_arbiter #(.MAX_BURST(MaxBurst)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // First requester set in r, scanning n positions upward from start with wrap; -1 if none.
   function automatic int search(input logic [7:0] r, input int start, input int n);
      for (int i = 0; i < n; i++) begin
         if (r[(start + i) % 8]) return (start + i) % 8;
      end
      return -1;
   endfunction

   function automatic logic [7:0] model_gnt();
      logic [7:0] g;
      g = 8'h00;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 7;
         m_run   = 0;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         int w;
         w = search(req, m_last + 1, 8);
         if (w >= 0) begin
            m_owner = w; m_last = w; m_sel = w; m_run = 1;
         end
      end else begin
         bit others, keep;
         int w;
         others = (req & ~(8'h01 << m_owner)) != 8'h00;
         keep   = req[m_owner] && !(LimitEn && (m_run == int'(MaxBurst)) && others);
         if (keep) begin
            m_run = (m_run < 255) ? m_run + 1 : 255;
         end else begin
            w = search(req, m_owner + 1, 7);
            if (w >= 0) begin
               m_owner = w; m_last = w; m_sel = w; m_run = 1;
            end else begin
               m_owner = -1;
            end
         end
      end
   end

   // Continuous comparison against the model whenever reset is released.
   always @(negedge clk) begin
      if (rst_n) begin
         check("model_gnt", 32'(gnt), 32'(model_gnt()));
         check("model_sel", 32'(sel), 32'(m_sel));
         check("model_busy", 32'(busy), 32'(m_owner >= 0));
      end
   end

   initial begin
      logic [7:0] r;
      rst_n = 1'b0;
      req   = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_sel", 32'(sel), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      // Idle with no requests.
      repeat (5) begin
         @(negedge clk);
         check("idle_gnt", 32'(gnt), 32'h0);
         check("idle_sel", 32'(sel), 32'h0);
         check("idle_busy", 32'(busy), 32'h0);
      end

      // All requesting: requester 0 first.
      req = 8'hFF;
      @(negedge clk);
      check("first_gnt", 32'(gnt), 32'h01);
      check("first_busy", 32'(busy), 32'h1);
`ifdef ARB_BURST_LIMIT_EN
      for (int n = 1; n < 36; n++) begin
         @(negedge clk);
         check("rotate_gnt", 32'(gnt), 32'(8'h01 << ((n / 4) % 8)));
         check("rotate_sel", 32'(sel), 32'((n / 4) % 8));
      end
`else
      repeat (6) begin
         @(negedge clk);
         check("hold_gnt", 32'(gnt), 32'h01);
      end
      req = 8'hFE;
      @(negedge clk);
      check("drop0_gnt", 32'(gnt), 32'h02);
      check("drop0_sel", 32'(sel), 32'h1);
`endif

      // Pointer wrap: owner 6 drops while 7 and 0 wait.
      req = 8'h00;
      @(negedge clk);
      check("to_idle_gnt", 32'(gnt), 32'h0);
      req = 8'h40;
      @(negedge clk);
      check("own6_gnt", 32'(gnt), 32'h40);
      req = 8'h81;
      @(negedge clk);
      check("wrap_gnt", 32'(gnt), 32'h80);
      check("wrap_sel", 32'(sel), 32'h7);

      // Lone requester is never preempted.
      req = 8'h00;
      @(negedge clk);
      req = 8'h10;
      repeat (20) begin
         @(negedge clk);
         check("lone_gnt", 32'(gnt), 32'h10);
      end
      req = 8'h00;
      @(negedge clk);
      check("lone_end_gnt", 32'(gnt), 32'h0);
      check("lone_end_busy", 32'(busy), 32'h0);
      check("lone_end_sel", 32'(sel), 32'h4);
      repeat (2) begin
         @(negedge clk);
         check("idle_sel_stable", 32'(sel), 32'h4);
      end

      // Asynchronous reset mid-grant.
      req = 8'h08;
      @(negedge clk);
      check("pre_rst_gnt", 32'(gnt), 32'h08);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_gnt", 32'(gnt), 32'h0);
      check("async_rst_sel", 32'(sel), 32'h0);
      check("async_rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      req   = 8'h09;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'h01);

      // Randomized traffic; owners usually keep requesting so bursts form.
      for (int c = 0; c < 3000; c++) begin
         r = 8'($urandom) & 8'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
         if ($urandom_range(0, 15) == 0) r = 8'h00;
         if ($urandom_range(0, 31) == 0) r = 8'hFF;
         req = r;
         @(negedge clk);
      end

      req = 8'h00;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
